mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
IEEE 802.3 Clause 22 MDIO management master. Generates MDC and serialises read/write management frames on the shared PHY management bus.
- Sits beside the MAC in the top level, driving the mdc/mdio pins.
- Top level builds the mdio inout from mdio_o/mdio_oe/mdio_i.
- Control logic issues one register access at a time through a valid/ready command port and gets a single-cycle response pulse.

Parameters:
CLK_DIV, 10, clk cycles per MDC half-period. Minimum 3. Default gives 25 MHz/20 = 1.25 MHz MDC.

Ports:
clk  input  1  system clock (25 MHz)
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high when idle; command accepted on cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_phy_addr  input  5  PHY address
cmd_reg_addr  input  5  register address
cmd_wdata  input  16  write data
rsp_valid  output  1  one-cycle pulse at frame completion
rsp_rdata  output  16  read data; valid when rsp_valid is high after a read
busy  output  1  frame in progress
mdc  output  1  management clock
mdio_o  output  1  MDIO output data
mdio_oe  output  1  MDIO output enable (1 = drive)
mdio_i  input  1  MDIO pin input

Behaviour:
- One clock; reset is synchronous and active-high on clk/rst.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, mdc=0, mdio_o=1, mdio_oe=0. FSM returns to IDLE.
- Reset mid-frame: abort immediately and release the bus next cycle. No rsp_valid is issued.
- FSM states: IDLE -> PREAMBLE (bits 0-31) -> HEADER (bits 32-45) -> TA (bits 46-47) -> DATA (bits 48-63) -> DONE -> IDLE.
- Acceptance: on acceptance at cycle 0, latch all cmd fields. cmd_ready=0 and busy=1 from cycle 1.
- cmd_valid while busy has no effect; fields are not sampled.
- Bit timing: bit i occupies clk cycles 1+2*CLK_DIV*i through 2*CLK_DIV*(i+1).
  - mdc=0 for the first CLK_DIV cycles, mdc=1 for the last CLK_DIV cycles.
  - mdio_o/mdio_oe change only on the first cycle of a low phase, so they are stable at the MDC rising edge.
- Frame contents, MSB first:
  - Bits 0-31: preamble, 32 ones.
  - ST = 01.
  - OP = 01 for write, 10 for read.
  - PHYAD[4:0], then REGAD[4:0].
  - TA: write drives 10; read releases the bus.
  - 16 data bits.
- mdio_oe:
  - Write: 1 for bits 0-63.
  - Read: 1 for bits 0-45, 0 for bits 46-63.
  - 0 in IDLE.
- Read capture: mdio_i passes through a 2-flop synchroniser. The synchronised value is sampled on the last cycle of the high phase of bits 48-63 and shifted MSB first.
- Completion: DONE lasts 1 cycle at cycle 128*CLK_DIV+1.
  - rsp_valid=1 in that cycle; the FSM is in IDLE the following cycle.
  - For reads, rsp_rdata updates in the DONE cycle. For writes, rsp_rdata holds its previous value.
  - cmd_ready=1 from cycle 128*CLK_DIV+2, so back-to-back commands leave one idle cycle.
- Divider counter: width is clog2(CLK_DIV). Reset to 0 on acceptance so MDC phase is aligned to each frame. mdc stays 0 in IDLE.

Optional Feature:
MDIO_READ_ERR_EN
- Defined: adds output rsp_err (1 bit, reset 0), valid with rsp_valid.
  - For reads, rsp_err=1 if the synchronised mdio_i sampled in the high phase of bit 47 (second TA bit) is 1, meaning no PHY responded.
  - For writes, rsp_err=0.
  - rsp_rdata is still updated with whatever was sampled.
- Undefined: port absent, and no TA sampling logic is built.

Test Plan:
- Write, CLK_DIV=4: accept cmd_write=1, phy=1, reg=0, wdata=0x1140.
  - Decoded on MDC rising edges: 32 ones, then 01 01 00001 00000 10 0001000101000000.
  - mdio_oe=1 throughout the frame.
  - rsp_valid pulses exactly at cycle 513.
  - rsp_rdata unchanged.
- Read, CLK_DIV=4: PHY model at address 3 returns 0x001C for reg 2; cmd phy=3, reg=2.
  - Header 01 10 00011 00010 on the bus.
  - mdio_oe falls at the start of bit 46 (cycle 369).
  - rsp_valid at cycle 513 with rsp_rdata=0x001C.
- Busy hold-off: hold cmd_valid=1 with changing fields during a frame.
  - No second acceptance until cmd_ready rises at cycle 514.
  - The second frame uses the fields present at cycle 514.
- Reset mid-frame: assert rst for 1 cycle at bit 40.
  - Next cycle: mdc=0, mdio_oe=0, cmd_ready=1, and no rsp_valid.
  - A new read then completes normally.
- CLK_DIV=10: MDC period measures 20 clk cycles with 50% duty; full frame takes 1280 cycles + DONE.
- MDIO_READ_ERR_EN defined, no PHY (mdio_i tied 1): read returns rsp_rdata=0xFFFF, rsp_err=1. With the PHY model present, rsp_err=0.

Source files
------------

// File: rtl/mdio_master_if.sv
// Command/response port of the Clause 22 MDIO master.
// rsp_err is only present when MDIO_READ_ERR_EN is defined.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
`ifdef MDIO_READ_ERR_EN
    logic        rsp_err;
`endif

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr,
        output cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
`ifdef MDIO_READ_ERR_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr,
        input  cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
`ifdef MDIO_READ_ERR_EN
        , output rsp_err
`endif
    );
endinterface

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22 MDIO master: MDC generation and frame serialiser.
// Define MDIO_READ_ERR_EN to add rsp_err (no PHY answered the read TA).
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic          clk,
    input  logic          rst,
    mdio_master_if.slave  bus,
    output logic          mdc,
    output logic          mdio_o,
    output logic          mdio_oe,
    input  logic          mdio_i
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DLAST = CW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]    state;
    logic [2:0]    nxt_state;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_idx;
    logic [5:0]    nb;
    logic [63:0]   frame;
    logic          is_wr;
    logic [15:0]   rd_sh;
    logic [15:0]   rd_next;
    logic          s1;
    logic          s2;
    logic          bit_end;

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign mdio_o        = frame[63];
    assign bit_end       = mdc && (cnt == DLAST);
    assign rd_next       = {rd_sh[14:0], s2};
    assign nb            = bit_idx + 6'd1;

    always_comb begin
        nxt_state = S_DATA;
        unique case (1'b1)
            (nb < 6'd32):                 nxt_state = S_PRE;
            (nb >= 6'd32 && nb < 6'd46):  nxt_state = S_HDR;
            (nb == 6'd46 || nb == 6'd47): nxt_state = S_TA;
            default:                      nxt_state = S_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        s1 <= mdio_i;
        s2 <= s1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            mdc           <= 1'b0;
            bit_idx       <= '0;
            frame         <= '1;
            mdio_oe       <= 1'b0;
            is_wr         <= 1'b0;
            rd_sh         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        state   <= S_PRE;
                        cnt     <= '0;
                        mdc     <= 1'b0;
                        bit_idx <= '0;
                        is_wr   <= bus.cmd_write;
                        mdio_oe <= 1'b1;
                        rd_sh   <= '0;
                        // reads park the TA/data slots high; oe drops there
                        frame   <= {32'hFFFF_FFFF, 2'b01,
                                    bus.cmd_write ? 2'b01 : 2'b10,
                                    bus.cmd_phy_addr, bus.cmd_reg_addr,
                                    bus.cmd_write ? 2'b10 : 2'b11,
                                    bus.cmd_write ? bus.cmd_wdata
                                                  : 16'hFFFF};
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    cnt <= (cnt == DLAST) ? '0 : cnt + CW'(1);
                    if (cnt == DLAST)
                        mdc <= ~mdc;
                    if (bit_end && bit_idx >= 6'd48)
                        rd_sh <= rd_next;
                    if (bit_end) begin
                        if (bit_idx == 6'd63) begin
                            state         <= S_DONE;
                            frame         <= '1;
                            mdio_oe       <= 1'b0;
                            bus.rsp_valid <= 1'b1;
                            if (!is_wr)
                                bus.rsp_rdata <= rd_next;
                        end else begin
                            state   <= nxt_state;
                            bit_idx <= nb;
                            frame   <= {frame[62:0], 1'b1};
                            mdio_oe <= is_wr || (nb < 6'd46);
                        end
                    end
                end
            endcase
        end
    end

`ifdef MDIO_READ_ERR_EN
    logic ta_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            ta_bad      <= 1'b0;
            bus.rsp_err <= 1'b0;
        end else begin
            if (state == S_TA && bit_end && bit_idx == 6'd47)
                ta_bad <= s2;
            if (state == S_DATA && bit_end && bit_idx == 6'd63)
                bus.rsp_err <= ~is_wr & ta_bad;
        end
    end
`else
    // without the TA check a silent PHY simply reads back as 16'hFFFF
`endif
endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: frame decode, PHY model, timing.
// Checks rsp_err too when built with MDIO_READ_ERR_EN.
module tb_mdio_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdio_master_if bus();
    mdio_master_if bus10();

    logic mdc, mdio_o, mdio_oe;
    logic mdio_i = 1'b1;
    logic mdc10, mdio_o10, mdio_oe10;

    mdio_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(10)) dut10 (
        .clk(clk), .rst(rst), .bus(bus10.slave),
        .mdc(mdc10), .mdio_o(mdio_o10), .mdio_oe(mdio_oe10),
        .mdio_i(1'b1)
    );

    typedef struct {
        logic        w;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic [31:0] frame_lo;
        logic [63:0] oe_mask;
        logic [15:0] rdata;
        logic        err;
        int          oe_fall;
    } vec_t;

    vec_t tv[5];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // PHY model at address 3 plus a bus decoder sampling on MDC rise
    function automatic logic [15:0] phy_reg(input logic [4:0] r);
        case (r)
            5'd2:    return 16'h001C;
            5'd3:    return 16'h7949;
            default: return 16'h0000;
        endcase
    endfunction

    logic [63:0] fr, oefr;
    logic [15:0] rd_word;
    logic        rd_hit = 1'b0;
    logic        mdc_q = 1'b0;
    int          nb = 0;

    always @(negedge clk) begin
        if (bus.cmd_ready) begin
            nb = 0;
            rd_hit = 1'b0;
            mdio_i <= 1'b1;
        end else if (mdc && !mdc_q && nb < 64) begin
            fr = {fr[62:0], mdio_oe ? mdio_o : mdio_i};
            oefr = {oefr[62:0], mdio_oe};
            nb++;
            if (nb == 46) begin
                rd_hit = (fr[11:10] == 2'b10) && (fr[9:5] == 5'd3);
                rd_word = phy_reg(fr[4:0]);
            end
        end else if (!mdc && mdc_q) begin
            if (rd_hit && nb == 47)
                mdio_i <= 1'b0;
            else if (rd_hit && nb >= 48 && nb <= 63)
                mdio_i <= rd_word[63 - nb];
            else
                mdio_i <= 1'b1;
        end
        mdc_q = mdc;
    end

    task automatic drive(input vec_t v);
        bus.cmd_write    = v.w;
        bus.cmd_phy_addr = v.phy;
        bus.cmd_reg_addr = v.rg;
        bus.cmd_wdata    = v.wd;
    endtask

    task automatic issue(input vec_t v);
        int n;
        @(negedge clk);
        drive(v);
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", bus.cmd_ready, 1);
        @(posedge clk);
    endtask

    task automatic wait_frame(input bit churn, input vec_t nxt,
                              output int rc, output int yc,
                              output int of, output int pu,
                              output logic b1);
        int c;
        logic prev_oe;
        c = 0; rc = -1; yc = -1; of = -1; pu = 0; b1 = 1'b0;
        prev_oe = 1'b1;
        while (yc < 0 && c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) b1 = bus.busy && !bus.cmd_ready;
            if (bus.rsp_valid) begin pu++; rc = c; end
            if (prev_oe && !mdio_oe && of < 0) of = c;
            prev_oe = mdio_oe;
            if (bus.cmd_ready) begin
                yc = c;
                if (churn) drive(nxt);
                else bus.cmd_valid = 1'b0;
            end else if (churn) begin
                bus.cmd_write    = 1'($urandom);
                bus.cmd_phy_addr = 5'($urandom);
                bus.cmd_reg_addr = 5'($urandom);
                bus.cmd_wdata    = 16'($urandom);
            end else if (c == 1) begin
                bus.cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input vec_t v, input int rc, input int yc,
                               input int of, input int pu, input logic b1);
        chk("busy_cycle1", b1, 1);
        chk("frame_bits", fr, {32'hFFFF_FFFF, v.frame_lo});
        chk("oe_bits", oefr, v.oe_mask);
        chk("rsp_cycle", rc, 513);
        chk("rsp_pulses", pu, 1);
        chk("ready_cycle", yc, 514);
        chk("oe_fall", of, v.oe_fall);
        chk("rsp_rdata", bus.rsp_rdata, v.rdata);
`ifdef MDIO_READ_ERR_EN
        chk("rsp_err", bus.rsp_err, v.err);
`endif
    endtask

    initial begin
        vec_t hv;
        int rc, yc, of, pu, c, r1, f1, r2;
        logic b1, pm;

        tv[0] = '{1'b1, 5'd1, 5'd0, 16'h1140, 32'h5082_1140,
                  64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0, 513};
        tv[1] = '{1'b0, 5'd3, 5'd2, 16'h0000, 32'h618A_001C,
                  64'hFFFF_FFFF_FFFC_0000, 16'h001C, 1'b0, 369};
        tv[2] = '{1'b0, 5'd5, 5'd2, 16'h0000, 32'h628B_FFFF,
                  64'hFFFF_FFFF_FFFC_0000, 16'hFFFF, 1'b1, 369};
        tv[3] = '{1'b1, 5'd31, 5'd31, 16'hA5A5, 32'h5FFE_A5A5,
                  64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b0, 513};
        tv[4] = '{1'b0, 5'd3, 5'd3, 16'h0000, 32'h618E_7949,
                  64'hFFFF_FFFF_FFFC_0000, 16'h7949, 1'b0, 369};

        bus.cmd_valid = 1'b0;
        drive(tv[0]);
        bus10.cmd_valid    = 1'b0;
        bus10.cmd_write    = 1'b1;
        bus10.cmd_phy_addr = 5'd1;
        bus10.cmd_reg_addr = 5'd0;
        bus10.cmd_wdata    = 16'h1234;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mdc", mdc, 0);
        chk("rst_mdio_o", mdio_o, 1);
        chk("rst_mdio_oe", mdio_oe, 0);
`ifdef MDIO_READ_ERR_EN
        chk("rst_err", bus.rsp_err, 0);
`endif

        for (int i = 0; i < 5; i++) begin
            issue(tv[i]);
            wait_frame(1'b0, tv[i], rc, yc, of, pu, b1);
            check_frame(tv[i], rc, yc, of, pu, b1);
        end

        // hold cmd_valid through a frame while fields keep changing
        hv = tv[0];
        hv.rdata = 16'h7949;
        issue(hv);
        wait_frame(1'b1, tv[1], rc, yc, of, pu, b1);
        check_frame(hv, rc, yc, of, pu, b1);
        wait_frame(1'b0, tv[1], rc, yc, of, pu, b1);
        check_frame(tv[1], rc, yc, of, pu, b1);

        // reset at the start of bit 40 of a read
        issue(tv[1]);
        pm = 1'b0;
        for (c = 1; c <= 321; c++) begin
            @(negedge clk);
            if (c == 1) bus.cmd_valid = 1'b0;
            if (bus.rsp_valid) pm = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_mdc", mdc, 0);
        chk("midrst_oe", mdio_oe, 0);
        chk("midrst_ready", bus.cmd_ready, 1);
        chk("midrst_rdata", bus.rsp_rdata, 0);
        for (int k = 0; k < 20; k++) begin
            if (bus.rsp_valid) pm = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_rsp", pm, 0);
        issue(tv[4]);
        wait_frame(1'b0, tv[4], rc, yc, of, pu, b1);
        check_frame(tv[4], rc, yc, of, pu, b1);

        // CLK_DIV=10 instance: MDC period/duty and frame length
        @(negedge clk);
        bus10.cmd_valid = 1'b1;
        @(posedge clk);
        c = 0; rc = -1; r1 = -1; f1 = -1; r2 = -1;
        pm = 1'b0;
        while (rc < 0 && c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) bus10.cmd_valid = 1'b0;
            if (mdc10 && !pm) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            if (!mdc10 && pm && f1 < 0) f1 = c;
            pm = mdc10;
            if (bus10.rsp_valid) rc = c;
        end
        chk("div10_first_rise", r1, 11);
        chk("div10_period", r2 - r1, 20);
        chk("div10_high", f1 - r1, 10);
        chk("div10_rsp_cycle", rc, 1281);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
